// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipe (priority) and an aux requester.
// Aux gets a forced grant after MAX_WAIT contended cycles; the pipe stalls that cycle.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  PIPE_PRI   | pipe owns memory when it requests; aux waits and counts
//  AUX_FORCED | aux owns memory for one cycle regardless of pipe_req
module dmem_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_req,
   input  logic [31:0] pipe_addr,
   input  logic        pipe_we,
   input  logic [31:0] pipe_wdata,
   input  logic [2:0]  pipe_width,
   output logic [31:0] pipe_rdata,
   output logic        pipe_stall,
   input  logic        aux_valid,
   input  logic [31:0] aux_addr,
   input  logic        aux_we,
   input  logic [31:0] aux_wdata,
   input  logic [2:0]  aux_width,
   output logic        aux_ready,
   output logic        aux_rvalid,
   output logic [31:0] aux_rdata,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_width,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {
      PIPE_PRI   = 1'b0,
      AUX_FORCED = 1'b1
   } state_t;

   localparam logic [4:0] MAX_WAIT_L = 5'(MAX_WAIT);

   state_t      state, state_nxt;
   logic [3:0]  wait_cnt, wait_cnt_nxt;
   logic [4:0]  wait_inc;
   logic        aux_xfer;

   assign wait_inc = {1'b0, wait_cnt} + 5'd1;
   assign aux_xfer = aux_valid && aux_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= PIPE_PRI;
         wait_cnt   <= 4'd0;
         aux_rvalid <= 1'b0;
         aux_rdata  <= 32'd0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_cnt_nxt;
         aux_rvalid <= aux_xfer && !aux_we;
         if (aux_xfer && !aux_we)
            aux_rdata <= mem_rdata;
      end
   end

   always_comb begin
      state_nxt    = PIPE_PRI;
      wait_cnt_nxt = 4'd0;
      aux_ready    = 1'b0;
      case (state)
         PIPE_PRI: begin
            aux_ready = aux_valid && !pipe_req;
            // Only a contended, ungranted cycle advances the wait history.
            if (aux_valid && pipe_req) begin
               wait_cnt_nxt = wait_inc[3:0];
               if (wait_inc == MAX_WAIT_L)
                  state_nxt = AUX_FORCED;
            end
         end
         AUX_FORCED: begin
            aux_ready = aux_valid;
         end
         default: begin
            aux_ready = 1'b0;
         end
      endcase
      // Gating with reset keeps memory and the pipe quiet while reset is held.
      if (!reset)
         aux_ready = 1'b0;
   end

   always_comb begin
      mem_addr   = pipe_addr;
      mem_width  = pipe_width;
      mem_wdata  = pipe_wdata;
      mem_we     = reset && pipe_req && pipe_we;
      if (aux_ready) begin
         mem_addr  = aux_addr;
         mem_width = aux_width;
         mem_wdata = aux_wdata;
         mem_we    = aux_we;
      end
   end

   assign pipe_stall = pipe_req && aux_ready;
   assign pipe_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word memory behind the mem_* port.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_req, pipe_we, aux_valid, aux_we;
   logic [31:0] pipe_addr, pipe_wdata, aux_addr, aux_wdata;
   logic [2:0]  pipe_width, aux_width;
   logic [31:0] pipe_rdata, aux_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        pipe_stall, aux_ready, aux_rvalid, mem_we;
   logic [2:0]  mem_width;

   logic [31:0] tb_mem [64];
   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .pipe_req(pipe_req), .pipe_addr(pipe_addr), .pipe_we(pipe_we),
      .pipe_wdata(pipe_wdata), .pipe_width(pipe_width),
      .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
      .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_we(aux_we),
      .aux_wdata(aux_wdata), .aux_width(aux_width),
      .aux_ready(aux_ready), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
      .mem_addr(mem_addr), .mem_width(mem_width), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = tb_mem[mem_addr[7:2]];
   always @(posedge clk)
      if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n contended cycles in which aux must stay ungranted and the pipe owns memory
   task automatic contend(input int n, input logic [31:0] paddr);
      for (int i = 0; i < n; i++) begin
         #1;
         chk($sformatf("wait_ready_c%0d", i), 32'(aux_ready), 32'd0);
         chk($sformatf("wait_stall_c%0d", i), 32'(pipe_stall), 32'd0);
         chk($sformatf("wait_addr_c%0d", i), mem_addr, paddr);
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) tb_mem[i] = 32'd0;
      reset = 1'b0;
      pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 32'h10; pipe_wdata = 32'h0;
      pipe_width = 3'b010;
      aux_valid = 1'b1; aux_we = 1'b1; aux_addr = 32'h20; aux_wdata = 32'h0;
      aux_width = 3'b010;
      #2;
      chk("rst_aux_ready", 32'(aux_ready), 32'd0);
      chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_aux_rvalid", 32'(aux_rvalid), 32'd0);
      chk("rst_aux_rdata", aux_rdata, 32'd0);
      tick();
      pipe_req = 1'b0; pipe_we = 1'b0; aux_valid = 1'b0; aux_we = 1'b0;
      reset = 1'b1;
      tick();

      // pipe only: store then load
      pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 32'h10; pipe_wdata = 32'hDEADBEEF;
      #1;
      chk("p_st_we", 32'(mem_we), 32'd1);
      chk("p_st_addr", mem_addr, 32'h10);
      chk("p_st_wdata", mem_wdata, 32'hDEADBEEF);
      chk("p_st_width", 32'(mem_width), 32'd2);
      chk("p_st_stall", 32'(pipe_stall), 32'd0);
      chk("p_st_ready", 32'(aux_ready), 32'd0);
      tick();
      pipe_we = 1'b0;
      #1;
      chk("p_ld_rdata", pipe_rdata, 32'hDEADBEEF);
      chk("p_ld_we", 32'(mem_we), 32'd0);
      chk("p_ld_stall", 32'(pipe_stall), 32'd0);
      tick();

      // aux load with idle pipe
      pipe_req = 1'b0;
      aux_valid = 1'b1; aux_we = 1'b0; aux_addr = 32'h10; aux_width = 3'b010;
      #1;
      chk("a_ld_ready", 32'(aux_ready), 32'd1);
      chk("a_ld_addr", mem_addr, 32'h10);
      chk("a_ld_we", 32'(mem_we), 32'd0);
      tick();
      aux_valid = 1'b0;
      #1;
      chk("a_ld_rvalid1", 32'(aux_rvalid), 32'd1);
      chk("a_ld_rdata", aux_rdata, 32'hDEADBEEF);
      tick();
      chk("a_ld_rvalid0", 32'(aux_rvalid), 32'd0);
      chk("a_ld_hold", aux_rdata, 32'hDEADBEEF);

      // starvation: pipe stores to 0x30 every cycle, aux store 0x55 to 0x20
      pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 32'h30; pipe_wdata = 32'h1111;
      aux_valid = 1'b1; aux_we = 1'b1; aux_addr = 32'h20; aux_wdata = 32'h55;
      #1;
      chk("sim_pipe_we", 32'(mem_we), 32'd1);
      chk("sim_wdata", mem_wdata, 32'h1111);
      contend(4, 32'h30);
      #1;
      chk("frc_ready", 32'(aux_ready), 32'd1);
      chk("frc_stall", 32'(pipe_stall), 32'd1);
      chk("frc_addr", mem_addr, 32'h20);
      chk("frc_wdata", mem_wdata, 32'h55);
      chk("frc_we", 32'(mem_we), 32'd1);
      tick();
      aux_valid = 1'b0;
      #1;
      chk("post_stall", 32'(pipe_stall), 32'd0);
      chk("post_ready", 32'(aux_ready), 32'd0);
      chk("post_addr", mem_addr, 32'h30);
      chk("post_rvalid", 32'(aux_rvalid), 32'd0);
      pipe_we = 1'b0; pipe_addr = 32'h20;
      #1;
      chk("aux_store_mem", pipe_rdata, 32'h55);
      tick();

      // reset at wait_cnt = 3 with an aux load pending
      pipe_we = 1'b1; pipe_addr = 32'h30; pipe_wdata = 32'h2222;
      aux_valid = 1'b1; aux_we = 1'b0; aux_addr = 32'h10;
      contend(3, 32'h30);
      reset = 1'b0;
      #1;
      chk("mid_rst_rvalid", 32'(aux_rvalid), 32'd0);
      chk("mid_rst_rdata", aux_rdata, 32'd0);
      chk("mid_rst_we", 32'(mem_we), 32'd0);
      chk("mid_rst_ready", 32'(aux_ready), 32'd0);
      tick();
      reset = 1'b1;
      contend(4, 32'h30);
      #1;
      chk("rst_grant_ready", 32'(aux_ready), 32'd1);
      chk("rst_grant_stall", 32'(pipe_stall), 32'd1);
      tick();
      chk("rst_grant_rvalid", 32'(aux_rvalid), 32'd1);
      chk("rst_grant_rdata", aux_rdata, 32'hDEADBEEF);

      // back-to-back aux: the next grant needs another full wait
      contend(4, 32'h30);
      #1;
      chk("b2b_ready", 32'(aux_ready), 32'd1);
      chk("b2b_stall", 32'(pipe_stall), 32'd1);
      tick();

      // aux drops valid while forced: no access, back to PIPE_PRI with a fresh count
      pipe_we = 1'b0;
      contend(4, 32'h30);
      aux_valid = 1'b0;
      #1;
      chk("drop_ready", 32'(aux_ready), 32'd0);
      chk("drop_stall", 32'(pipe_stall), 32'd0);
      chk("drop_we", 32'(mem_we), 32'd0);
      chk("drop_addr", mem_addr, 32'h30);
      tick();
      aux_valid = 1'b1;
      chk("drop_rvalid", 32'(aux_rvalid), 32'd0);
      contend(4, 32'h30);
      #1;
      chk("drop_regrant", 32'(aux_ready), 32'd1);
      tick();
      aux_valid = 1'b0; pipe_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single-port data memory between the memory-access stage (pipe port) and an auxiliary requester such as a debug or program loader (aux port). The pipe port has priority. An aux request that has waited MAX_WAIT cycles is force-granted, and the pipeline is stalled for that cycle. Sits between the memory-access stage, the hazard/stall logic and the data memory, and drives all data-memory inputs.

## Interface
- MAX_WAIT, default 4: contended cycles an aux request may wait before it is force-granted. Legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pipe_req  in  1  memory-access stage performs a load or store this cycle.
- pipe_addr  in  32  pipe byte address.
- pipe_we  in  1  pipe store enable.
- pipe_wdata  in  32  pipe store data.
- pipe_width  in  3  pipe access width/sign code, passed unchanged to memory.
- pipe_rdata  out  32  memory read data to the pipe (combinational).
- pipe_stall  out  1  pipe access not served this cycle; hold the pipeline.
- aux_valid  in  1  aux request pending.
- aux_addr  in  32  aux byte address.
- aux_we  in  1  aux store enable.
- aux_wdata  in  32  aux store data.
- aux_width  in  3  aux width code.
- aux_ready  out  1  aux owns memory this cycle; a transfer occurs when aux_valid && aux_ready.
- aux_rvalid  out  1  one-cycle pulse: aux_rdata holds load data.
- aux_rdata  out  32  registered aux load data.
- mem_addr  out  32  address to the data memory.
- mem_width  out  3  width code to the data memory.
- mem_we  out  1  write enable to the data memory.
- mem_wdata  out  32  write data to the data memory.
- mem_rdata  in  32  data-memory read data (combinational, same cycle).

## Operation
- FSM with two states:
  - PIPE_PRI (reset state): aux_ready = aux_valid && !pipe_req.
  - AUX_FORCED: aux_ready = aux_valid, regardless of pipe_req.
- Owner each cycle is aux if aux_ready is high, otherwise pipe.
- Memory mux:
  - mem_addr, mem_width and mem_wdata come from the owner's inputs.
  - mem_we = owner is aux ? aux_we : (pipe_req && pipe_we).
  - A non-owner never writes memory.
- pipe_stall = pipe_req && aux_ready.
- pipe_rdata = mem_rdata, always.
- Wait counter wait_cnt, 4 bits:
  - In PIPE_PRI, when aux_valid && pipe_req: increment wait_cnt. If wait_cnt+1 == MAX_WAIT, move to AUX_FORCED.
  - Clear wait_cnt to 0 on any aux transfer, or when aux_valid is low.
- AUX_FORCED lasts exactly one cycle:
  - If aux_valid is high, the transfer occurs, then return to PIPE_PRI with wait_cnt = 0.
  - If aux_valid is low (protocol violation), return to PIPE_PRI with wait_cnt = 0 and no memory access.
- Aux protocol: once aux_valid rises, aux_addr, aux_we, aux_wdata and aux_width stay stable until the transfer. The arbiter does not check this.
- Aux load (transfer with aux_we = 0):
  - On that edge, aux_rdata <= mem_rdata and aux_rvalid <= 1 for the following cycle.
  - aux_rvalid is 0 after a store or when there is no transfer.
  - aux_rdata holds its value until the next aux load.
- Reset (reset low, asynchronous):
  - State = PIPE_PRI, wait_cnt = 0, aux_rvalid = 0, aux_rdata = 0.
  - aux_ready, mem_we and pipe_stall are forced to 0 while reset is low.
  - Reset mid-wait discards the wait history; a pending aux request re-arbitrates from zero.

## Timing
- Pipe access: zero added latency. Read data is combinational in the same cycle; a store commits at the next edge.
- Aux access with an idle pipe: granted in the same cycle aux_valid rises. Load data is valid (aux_rvalid = 1) on the following cycle.
- Aux under continuous pipe traffic: waits exactly MAX_WAIT cycles, is granted on cycle MAX_WAIT+1, and pipe_stall is high for exactly that one cycle.
- Back-to-back aux requests under continuous pipe traffic: at most one stall cycle per MAX_WAIT+1 cycles.
- While pipe_stall is high, the pipe holds all pipe_* inputs. The stalled access is served the next cycle.

## Test plan
- Pipe only: store 0xDEADBEEF at 0x10, width word, then load 0x10 → pipe_rdata = 0xDEADBEEF in the load cycle, pipe_stall stays 0, aux_ready stays 0.
- Aux with idle pipe: aux load of 0x10 → aux_ready = 1 in the same cycle; the next cycle aux_rvalid = 1 and aux_rdata = 0xDEADBEEF; the cycle after, aux_rvalid = 0.
- Starvation, MAX_WAIT = 4, pipe_req held high, aux store 0x55 to 0x20 raised at cycle 0 → aux_ready = 0 in cycles 0–3, aux_ready = 1 and pipe_stall = 1 in cycle 4, mem_we sourced from aux only in cycle 4; cycle 5 back to pipe with pipe_stall = 0.
- Simultaneous requests in PIPE_PRI with wait_cnt = 0 → pipe served, mem_we follows pipe_we, aux_ready = 0, wait_cnt = 1.
- Reset asserted at wait_cnt = 3 with aux pending → immediately aux_rvalid = 0, aux_rdata = 0, mem_we = 0; after release, aux needs 4 more contended cycles before it is granted.
- aux_valid dropped while in AUX_FORCED → no write occurs (mem_we = 0 for the aux side), FSM returns to PIPE_PRI with wait_cnt = 0.
